keyboard_ctrl: RTL and testbench
================================

# keyboard_ctrl

Sits between the PS/2 serial receiver and `convert_to_binary`. It consumes the receiver's byte stream and filters it with a break-code state machine. Make codes and typematic repeats are dropped; each key is reported once, on release. The released key's make code goes to `convert_to_binary`, and the last four released codes are kept in a shift buffer for the seven-segment display path.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 100000: idle clock cycles allowed in a non-IDLE state before the FSM aborts to IDLE (1 ms at 100 MHz).

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  one clock; reset is asynchronous and active-low
- `scan_code_in`  in  8  byte from PS/2 receiver
- `scan_valid`  in  1  one-cycle strobe; `scan_code_in` valid this cycle
- `scan_code_out`  out  8  make code of most recently released key; feeds `convert_to_binary`
- `code_valid`  out  1  one-cycle pulse, `scan_code_out` just updated
- `digit_buf`  out  32  last four released codes; `[7:0]` newest, `[31:24]` oldest

## Operation

- FSM states: IDLE, BREAK (F0 seen), EXT (E0 seen), EXT_BREAK (E0 F0 seen). The FSM advances only on cycles with `scan_valid`=1; otherwise it holds.
- Error bytes 8'h00 and 8'hFF in any state:
  - FSM goes to IDLE.
  - No capture.
  - Timeout counter clears.
- IDLE:
  - F0 goes to BREAK.
  - E0 goes to EXT.
  - Any other byte (make or typematic repeat) is ignored; stay in IDLE.
- BREAK:
  - F0 stays in BREAK, no capture.
  - E0 goes to EXT (protocol resync).
  - Any other byte X is captured, then the FSM goes to IDLE.
- EXT:
  - F0 goes to EXT_BREAK.
  - Any other byte (extended make) goes to IDLE.
- EXT_BREAK:
  - The next non-error byte X goes to IDLE.
  - X is captured only when extended keys are enabled (see Configuration).
- Capture of X:
  - `scan_code_out` <= X.
  - `digit_buf` <= {`digit_buf[23:0]`, X}.
  - `code_valid` <= 1 for exactly one cycle.
- Timeout counter:
  - Clears on every accepted byte and whenever the state is IDLE.
  - Increments each cycle while the state is not IDLE and `scan_valid`=0.
  - When it reaches `TIMEOUT_CYCLES`-1, the FSM goes to IDLE and the counter clears. No capture.
  - Counter width is $clog2(`TIMEOUT_CYCLES`).

## Timing

- Reset values:
  - state IDLE
  - `scan_code_out` 8'h00 (converter shows blank, 4'hF)
  - `code_valid` 0
  - `digit_buf` 32'h0
  - timeout counter 0
- Latency: a capture byte sampled at edge N appears on `scan_code_out`/`digit_buf`, with `code_valid`=1, after edge N. `code_valid` drops after edge N+1 unless another capture occurs.
- Back-to-back `scan_valid` is legal every cycle. Two captures on consecutive bytes give two consecutive `code_valid` cycles.
- Timeout and `scan_valid` in the same cycle: the byte wins. It is processed normally and the counter clears.
- Async reset mid-sequence (e.g. in BREAK): everything returns to reset values immediately. The next byte is interpreted from IDLE.
- No backpressure. Every strobed byte is consumed in its cycle.

## Configuration

- `KB_EXT_KEYS_EN` defined: extended releases (E0 F0 X) capture X exactly like a normal release.
- Undefined: EXT and EXT_BREAK still exist and swallow extended sequences; X is discarded. `code_valid` never pulses for E0-prefixed keys.
- The four-state FSM encoding is identical in both builds.

## Structure

- Shared package `kb_pkg`:
  - constants `KB_BREAK_CODE`=8'hF0, `KB_EXT_CODE`=8'hE0, `KB_ERR0_CODE`=8'h00, `KB_ERR1_CODE`=8'hFF
  - FSM state typedef `kb_state_t`
- One sub-module, `kb_timeout`:
  - inputs `clk`, `rst_n`, `clear`, `run`
  - output `expired`, one-cycle pulse
  - parameterised by `TIMEOUT_CYCLES`
- FSM, capture register and shift buffer live in `keyboard_ctrl`.

## Test plan

- Bytes 16, 16, F0, 16 (typematic then release) -> exactly one `code_valid`; `scan_code_out`=16; `digit_buf`=32'h00000016.
- Releases 45, 16, 1E, 26, 25 -> `digit_buf`=32'h161E2625; `scan_code_out`=25; five `code_valid` pulses.
- E0, F0, 5A -> `scan_code_out`=5A with `KB_EXT_KEYS_EN`; no pulse and outputs unchanged without it.
- F0 then `TIMEOUT_CYCLES` idle cycles, then 1E -> no capture (FSM back in IDLE). Repeat with 1E strobed on cycle `TIMEOUT_CYCLES`-1 -> same-cycle priority: captured.
- F0, FF, 16 -> no capture (error resets to IDLE). Then F0, F0, 16 -> one capture of 16.
- `rst_n` asserted asynchronously between F0 and 16 -> outputs return to reset values immediately; the following 16 is not captured.

Source files
------------

// File: rtl/kb_pkg.sv
// Shared constants and FSM state type for the PS/2 keyboard break-code filter.
package kb_pkg;

  localparam logic [7:0] KB_BREAK_CODE = 8'hF0;
  localparam logic [7:0] KB_EXT_CODE   = 8'hE0;
  localparam logic [7:0] KB_ERR0_CODE  = 8'h00;
  localparam logic [7:0] KB_ERR1_CODE  = 8'hFF;

  typedef logic [1:0] kb_state_t;

  localparam kb_state_t KB_IDLE      = 2'd0;
  localparam kb_state_t KB_BREAK     = 2'd1;
  localparam kb_state_t KB_EXT       = 2'd2;
  localparam kb_state_t KB_EXT_BREAK = 2'd3;

endpackage

// File: rtl/keyboard_ctrl_if.sv
// Byte stream from the PS/2 receiver and released-key outputs toward the display path.
interface keyboard_ctrl_if;

  logic [7:0]  scan_code_in;
  logic        scan_valid;
  logic [7:0]  scan_code_out;
  logic        code_valid;
  logic [31:0] digit_buf;

  modport master (
    output scan_code_in,
    output scan_valid,
    input  scan_code_out,
    input  code_valid,
    input  digit_buf
  );

  modport slave (
    input  scan_code_in,
    input  scan_valid,
    output scan_code_out,
    output code_valid,
    output digit_buf
  );

endinterface

// File: rtl/kb_timeout.sv
// Idle watchdog: pulses 'expired' for one cycle when a prefix sequence has stalled
// for TIMEOUT_CYCLES cycles without a new byte.
module kb_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = run && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || expired) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keyboard_ctrl.sv
// Break-code filter between the PS/2 receiver and convert_to_binary: reports each key once on release.
// Define KB_EXT_KEYS_EN to also report E0-prefixed (extended) key releases.
module keyboard_ctrl #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic            clk,
  input  logic            rst_n,
  keyboard_ctrl_if.slave  kb
);

  import kb_pkg::*;

  kb_state_t   state_q, state_d;
  logic        capture_d;
  logic [7:0]  code_q;
  logic        valid_q;
  logic [31:0] buf_q;
  logic        expired;
  logic        isError;

  assign isError = (kb.scan_code_in == KB_ERR0_CODE) || (kb.scan_code_in == KB_ERR1_CODE);

  kb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (kb.scan_valid || (state_q == KB_IDLE)),
    .run     (!kb.scan_valid && (state_q != KB_IDLE)),
    .expired (expired)
  );

  // A strobed byte always takes priority over a timeout in the same cycle.
  always_comb begin
    state_d   = state_q;
    capture_d = 1'b0;
    if (kb.scan_valid) begin
      if (isError) begin
        state_d = KB_IDLE;
      end else begin
        case (state_q)
          KB_IDLE: begin
            if (kb.scan_code_in == KB_BREAK_CODE) begin
              state_d = KB_BREAK;
            end else if (kb.scan_code_in == KB_EXT_CODE) begin
              state_d = KB_EXT;
            end
          end
          KB_BREAK: begin
            if (kb.scan_code_in == KB_EXT_CODE) begin
              state_d = KB_EXT;
            end else if (kb.scan_code_in != KB_BREAK_CODE) begin
              capture_d = 1'b1;
              state_d   = KB_IDLE;
            end
          end
          KB_EXT: begin
            if (kb.scan_code_in == KB_BREAK_CODE) begin
              state_d = KB_EXT_BREAK;
            end else begin
              state_d = KB_IDLE;
            end
          end
          KB_EXT_BREAK: begin
            state_d = KB_IDLE;
`ifdef KB_EXT_KEYS_EN
            capture_d = 1'b1;
`endif
          end
          default: state_d = KB_IDLE;
        endcase
      end
    end else if (expired) begin
      state_d = KB_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= KB_IDLE;
      code_q  <= 8'h00;
      valid_q <= 1'b0;
      buf_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      valid_q <= capture_d;
      if (capture_d) begin
        code_q <= kb.scan_code_in;
        buf_q  <= {buf_q[23:0], kb.scan_code_in};
      end
    end
  end

  assign kb.scan_code_out = code_q;
  assign kb.code_valid    = valid_q;
  assign kb.digit_buf     = buf_q;

endmodule

// File: tb/tb_keyboard_ctrl.sv
// Self-checking bench for keyboard_ctrl: directed scenarios plus randomized traffic
// against a queue-based model of the release-reporting rules.
module tb_keyboard_ctrl;

  localparam int TO = 16;

  logic clk;
  logic rst_n;
  int   assertCount;
  int   failCount;

  keyboard_ctrl_if kbIf ();

  keyboard_ctrl #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kb    (kbIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 'pend' holds the unfinished prefix bytes, 'hist' the released codes.
  logic [7:0]  pend [$];
  logic [7:0]  hist [$];
  logic [7:0]  expCode;
  logic        expPulse;
  int          idleCnt;

  function automatic logic [31:0] expBuf();
    logic [31:0] b = 32'h0;
    foreach (hist[i]) b = {b[23:0], hist[i]};
    return b;
  endfunction

  task automatic modelReset();
    pend.delete();
    hist.delete();
    expCode  = 8'h00;
    expPulse = 1'b0;
    idleCnt  = 0;
  endtask

  task automatic modelCapture(input logic [7:0] b);
    expCode  = b;
    expPulse = 1'b1;
    hist.push_back(b);
    if (hist.size() > 4) void'(hist.pop_front());
  endtask

  task automatic modelApply(input logic v, input logic [7:0] b);
    expPulse = 1'b0;
    if (v) begin
      idleCnt = 0;
      if (b == 8'h00 || b == 8'hFF) begin
        pend.delete();
      end else if (pend.size() == 0) begin
        if (b == 8'hF0 || b == 8'hE0) pend.push_back(b);
      end else if (pend[0] == 8'hE0 && pend.size() == 2) begin
`ifdef KB_EXT_KEYS_EN
        modelCapture(b);
`endif
        pend.delete();
      end else if (pend[0] == 8'hE0) begin
        if (b == 8'hF0) pend.push_back(b);
        else pend.delete();
      end else begin
        if (b == 8'hE0) begin
          pend.delete();
          pend.push_back(8'hE0);
        end else if (b != 8'hF0) begin
          modelCapture(b);
          pend.delete();
        end
      end
    end else if (pend.size() != 0) begin
      idleCnt++;
      if (idleCnt == TO) begin
        pend.delete();
        idleCnt = 0;
      end
    end
  endtask

  // Drives one cycle, then leaves the bench 1 time unit after the rising edge.
  task automatic applyStimulus(input logic v, input logic [7:0] b);
    kbIf.scan_valid   = v;
    kbIf.scan_code_in = b;
    @(posedge clk);
    #1;
    kbIf.scan_valid   = 1'b0;
    kbIf.scan_code_in = 8'h00;
    modelApply(v, b);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    kbIf.scan_valid = 1'b0;
    kbIf.scan_code_in = 8'h00;
    modelReset();
    #3;
    assertCount++;
    if (kbIf.scan_code_out !== 8'h00) begin
      failCount++;
      $display("[TB] FAIL reset_code: got %h expected %h", kbIf.scan_code_out, 8'h00);
    end
    assertCount++;
    if (kbIf.code_valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_valid: got %b expected 0", kbIf.code_valid);
    end
    assertCount++;
    if (kbIf.digit_buf !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL reset_buf: got %h expected %h", kbIf.digit_buf, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_typematic_release();
    logic [7:0] seq [4] = '{8'h16, 8'h16, 8'hF0, 8'h16};
    int pulses = 0;
    foreach (seq[i]) begin
      applyStimulus(1'b1, seq[i]);
      if (kbIf.code_valid === 1'b1) pulses++;
      assertCount++;
      if (kbIf.code_valid !== expPulse) begin
        failCount++;
        $display("[TB] FAIL typematic_pulse[%0d]: got %b expected %b", i, kbIf.code_valid, expPulse);
      end
    end
    applyStimulus(1'b0, 8'h00);
    assertCount++;
    if (pulses != 1) begin
      failCount++;
      $display("[TB] FAIL typematic_count: got %0d expected 1", pulses);
    end
    assertCount++;
    if (kbIf.scan_code_out !== 8'h16) begin
      failCount++;
      $display("[TB] FAIL typematic_code: got %h expected 16", kbIf.scan_code_out);
    end
    assertCount++;
    if (kbIf.digit_buf !== 32'h00000016) begin
      failCount++;
      $display("[TB] FAIL typematic_buf: got %h expected 00000016", kbIf.digit_buf);
    end
  endtask

  task automatic test_shift_buffer();
    logic [7:0] keys [5] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25};
    int pulses = 0;
    foreach (keys[i]) begin
      applyStimulus(1'b1, 8'hF0);
      if (kbIf.code_valid === 1'b1) pulses++;
      applyStimulus(1'b1, keys[i]);
      if (kbIf.code_valid === 1'b1) pulses++;
      assertCount++;
      if (kbIf.digit_buf !== expBuf()) begin
        failCount++;
        $display("[TB] FAIL shift_buf[%0d]: got %h expected %h", i, kbIf.digit_buf, expBuf());
      end
    end
    assertCount++;
    if (pulses != 5) begin
      failCount++;
      $display("[TB] FAIL shift_count: got %0d expected 5", pulses);
    end
    assertCount++;
    if (kbIf.digit_buf !== 32'h161E2625) begin
      failCount++;
      $display("[TB] FAIL shift_final_buf: got %h expected 161E2625", kbIf.digit_buf);
    end
    assertCount++;
    if (kbIf.scan_code_out !== 8'h25) begin
      failCount++;
      $display("[TB] FAIL shift_code: got %h expected 25", kbIf.scan_code_out);
    end
  endtask

  task automatic test_extended();
    logic [31:0] bufBefore = expBuf();
    applyStimulus(1'b1, 8'hE0);
    applyStimulus(1'b1, 8'hF0);
    applyStimulus(1'b1, 8'h5A);
`ifdef KB_EXT_KEYS_EN
    assertCount++;
    if (kbIf.code_valid !== 1'b1 || kbIf.scan_code_out !== 8'h5A) begin
      failCount++;
      $display("[TB] FAIL ext_capture: got valid=%b code=%h expected valid=1 code=5A", kbIf.code_valid, kbIf.scan_code_out);
    end
    assertCount++;
    if (kbIf.digit_buf !== {bufBefore[23:0], 8'h5A}) begin
      failCount++;
      $display("[TB] FAIL ext_buf: got %h expected %h", kbIf.digit_buf, {bufBefore[23:0], 8'h5A});
    end
`else
    assertCount++;
    if (kbIf.code_valid !== 1'b0 || kbIf.scan_code_out !== 8'h25) begin
      failCount++;
      $display("[TB] FAIL ext_swallow: got valid=%b code=%h expected valid=0 code=25", kbIf.code_valid, kbIf.scan_code_out);
    end
    assertCount++;
    if (kbIf.digit_buf !== bufBefore) begin
      failCount++;
      $display("[TB] FAIL ext_buf: got %h expected %h", kbIf.digit_buf, bufBefore);
    end
`endif
    applyStimulus(1'b1, 8'hE0);
    applyStimulus(1'b1, 8'h5A);
    assertCount++;
    if (kbIf.code_valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL ext_make: got %b expected 0", kbIf.code_valid);
    end
  endtask

  task automatic test_timeout();
    applyStimulus(1'b1, 8'hF0);
    repeat (TO) applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b1, 8'h1E);
    assertCount++;
    if (kbIf.code_valid !== 1'b0 || kbIf.scan_code_out !== expCode) begin
      failCount++;
      $display("[TB] FAIL timeout_abort: got valid=%b code=%h expected valid=0 code=%h", kbIf.code_valid, kbIf.scan_code_out, expCode);
    end
    applyStimulus(1'b1, 8'hF0);
    repeat (TO - 1) applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b1, 8'h1E);
    assertCount++;
    if (kbIf.code_valid !== 1'b1 || kbIf.scan_code_out !== 8'h1E) begin
      failCount++;
      $display("[TB] FAIL timeout_priority: got valid=%b code=%h expected valid=1 code=1E", kbIf.code_valid, kbIf.scan_code_out);
    end
  endtask

  task automatic test_errors();
    logic [7:0] codeBefore = expCode;
    applyStimulus(1'b1, 8'hF0);
    applyStimulus(1'b1, 8'hFF);
    applyStimulus(1'b1, 8'h16);
    assertCount++;
    if (kbIf.code_valid !== 1'b0 || kbIf.scan_code_out !== codeBefore) begin
      failCount++;
      $display("[TB] FAIL error_abort: got valid=%b code=%h expected valid=0 code=%h", kbIf.code_valid, kbIf.scan_code_out, codeBefore);
    end
    applyStimulus(1'b1, 8'hF0);
    applyStimulus(1'b1, 8'hF0);
    assertCount++;
    if (kbIf.code_valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL error_double_break: got %b expected 0", kbIf.code_valid);
    end
    applyStimulus(1'b1, 8'h16);
    assertCount++;
    if (kbIf.code_valid !== 1'b1 || kbIf.scan_code_out !== 8'h16) begin
      failCount++;
      $display("[TB] FAIL error_recover: got valid=%b code=%h expected valid=1 code=16", kbIf.code_valid, kbIf.scan_code_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [4] = '{8'hF0, 8'h1E, 8'hF0, 8'h26};
    logic       want [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    foreach (seq[i]) begin
      applyStimulus(1'b1, seq[i]);
      assertCount++;
      if (kbIf.code_valid !== want[i]) begin
        failCount++;
        $display("[TB] FAIL b2b_pulse[%0d]: got %b expected %b", i, kbIf.code_valid, want[i]);
      end
    end
    applyStimulus(1'b0, 8'h00);
    assertCount++;
    if (kbIf.code_valid !== 1'b0 || kbIf.scan_code_out !== 8'h26) begin
      failCount++;
      $display("[TB] FAIL b2b_drop: got valid=%b code=%h expected valid=0 code=26", kbIf.code_valid, kbIf.scan_code_out);
    end
  endtask

  task automatic test_async_reset();
    applyStimulus(1'b1, 8'hF0);
    #3;
    rst_n = 1'b0;
    #1;
    modelReset();
    assertCount++;
    if (kbIf.scan_code_out !== 8'h00 || kbIf.digit_buf !== 32'h0 || kbIf.code_valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL async_reset: got code=%h buf=%h valid=%b expected 00/00000000/0", kbIf.scan_code_out, kbIf.digit_buf, kbIf.code_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h16);
    assertCount++;
    if (kbIf.code_valid !== 1'b0 || kbIf.digit_buf !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL async_reset_next: got valid=%b buf=%h expected 0/00000000", kbIf.code_valid, kbIf.digit_buf);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h5A, 8'hF0, 8'hF0, 8'hE0, 8'h00, 8'hFF};
    int gap = 0;
    for (int i = 0; i < 600; i++) begin
      if (gap == 0 && $urandom_range(0, 39) == 0) gap = TO - 2 + int'($urandom_range(0, 4));
      if (gap > 0) begin
        gap--;
        applyStimulus(1'b0, 8'h00);
      end else begin
        applyStimulus(($urandom_range(0, 9) < 6), pool[$urandom_range(0, 9)]);
      end
      assertCount++;
      if (kbIf.code_valid !== expPulse || kbIf.scan_code_out !== expCode || kbIf.digit_buf !== expBuf()) begin
        failCount++;
        $display("[TB] FAIL random[%0d]: got valid=%b code=%h buf=%h expected valid=%b code=%h buf=%h",
                 i, kbIf.code_valid, kbIf.scan_code_out, kbIf.digit_buf, expPulse, expCode, expBuf());
      end
    end
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    test_reset();
    test_typematic_release();
    test_shift_buffer();
    test_extended();
    test_timeout();
    test_errors();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
